// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
// Shared definitions for the memory-access stage: operation codes (also used
// by execute and write-back), stack-sequencer state encoding and the default
// stack pointer reset value.
package memory_stage_pkg;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_07FF;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } op_kind_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALL2 = 3'd1,
        S_RET2  = 3'd2,
        S_INT2  = 3'd3,
        S_INT3  = 3'd4,
        S_RTI2  = 3'd5,
        S_RTI3  = 3'd6
    } state_e;

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if
// Data-memory port between the memory stage (master) and the data memory
// (slave). Read data is combinational on addr; writes land on the clock edge.
//   addr  : word address
//   re/we : read / write strobes
//   wdata : write data
//   rdata : read data returned by the memory
interface memory_stage_if;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output addr, re, we, wdata, input rdata);
    modport slave  (input addr, re, we, wdata, output rdata);
endinterface

// File: rtl/memory_stage_sp_counter.sv
// sp_counter
// 32-bit stack pointer register. Resets to SP_INIT; dec has priority over inc
// (the sequencer never asserts both). Arithmetic wraps modulo 2^32.
//   clk, reset : clock, synchronous active-high reset
//   dec, inc   : decrement / increment by one at the clock edge
//   sp         : current stack pointer
module sp_counter #(
    parameter logic [31:0] SP_INIT = 32'h0000_07FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec,
    input  logic        inc,
    output logic [31:0] sp
);

    logic [31:0] sp_q;
    logic [31:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (dec) begin
            sp_d = sp_q - 32'd1;
        end else if (inc) begin
            sp_d = sp_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= SP_INIT;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp = sp_q;

endmodule

// File: rtl/memory_stage.sv
// memory_stage
// Memory-access stage: performs LOAD/STORE/PUSH/POP in one cycle and
// sequences CALL/RET (2 cycles) and INT/RTI (3 cycles) on the stack.
//   clk, reset          : clock, synchronous active-high reset
//   op_valid, op_kind   : operation from the execute/memory buffer
//   alu_result          : LOAD/STORE address
//   store_data          : STORE/PUSH data
//   pc_in, ccr_in       : return PC and flags saved by CALL/INT
//   dmem                : data-memory port (master)
//   stall               : hold upstream while a sequence is in progress
//   load_valid/load_data: LOAD/POP result for write-back
//   pc_load/pc_out      : restored PC for fetch (RET/RTI)
//   ccr_load/ccr_out    : restored flags (RTI)
//   sp                  : current stack pointer
//
// state | meaning
// IDLE  | accepting ops; first cycle of every sequence runs here
// CALL2 | push pc high
// RET2  | pop pc low, load pc
// INT2  | push pc low
// INT3  | push pc high
// RTI2  | pop pc low
// RTI3  | pop ccr, load pc and flags
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [3:0]            op_kind,
    input  logic [15:0]           alu_result,
    input  logic [15:0]           store_data,
    input  logic [31:0]           pc_in,
    input  logic [3:0]            ccr_in,
    memory_stage_if.master        dmem,
    output logic                  stall,
    output logic                  load_valid,
    output logic [15:0]           load_data,
    output logic                  pc_load,
    output logic [31:0]           pc_out,
    output logic                  ccr_load,
    output logic [3:0]            ccr_out,
    output logic [31:0]           sp
);

    state_e      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] pc_q, pc_d;

    logic        sp_dec, sp_inc;
    logic [15:0] push_addr, pop_addr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_re, mem_we;

    sp_counter #(.SP_INIT(SP_INIT)) u_sp (
        .clk   (clk),
        .reset (reset),
        .dec   (sp_dec),
        .inc   (sp_inc),
        .sp    (sp)
    );

    assign push_addr = sp[15:0];
    assign pop_addr  = sp[15:0] + 16'd1;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pc_d       = pc_q;
        sp_dec     = 1'b0;
        sp_inc     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        stall      = 1'b0;
        load_valid = 1'b0;
        pc_load    = 1'b0;
        pc_out     = 32'h0000_0000;
        ccr_load   = 1'b0;
        ccr_out    = 4'h0;

        // Gating everything on reset keeps strobes quiet and aborts any
        // sequence in progress without a final write or pc/ccr load.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_kind)
                            OP_LOAD: begin
                                mem_re     = 1'b1;
                                mem_addr   = alu_result;
                                load_valid = 1'b1;
                            end
                            OP_STORE: begin
                                mem_we    = 1'b1;
                                mem_addr  = alu_result;
                                mem_wdata = store_data;
                            end
                            OP_PUSH: begin
                                mem_we    = 1'b1;
                                mem_addr  = push_addr;
                                mem_wdata = store_data;
                                sp_dec    = 1'b1;
                            end
                            OP_POP: begin
                                mem_re     = 1'b1;
                                mem_addr   = pop_addr;
                                load_valid = 1'b1;
                                sp_inc     = 1'b1;
                            end
                            OP_CALL: begin
                                mem_we    = 1'b1;
                                mem_addr  = push_addr;
                                mem_wdata = pc_in[15:0];
                                sp_dec    = 1'b1;
                                pc_d      = pc_in;
                                stall     = 1'b1;
                                state_d   = S_CALL2;
                            end
                            OP_RET: begin
                                mem_re   = 1'b1;
                                mem_addr = pop_addr;
                                sp_inc   = 1'b1;
                                hi_d     = dmem.rdata;
                                stall    = 1'b1;
                                state_d  = S_RET2;
                            end
                            OP_INT: begin
                                mem_we    = 1'b1;
                                mem_addr  = push_addr;
                                mem_wdata = {12'h000, ccr_in};
                                sp_dec    = 1'b1;
                                pc_d      = pc_in;
                                stall     = 1'b1;
                                state_d   = S_INT2;
                            end
                            OP_RTI: begin
                                mem_re   = 1'b1;
                                mem_addr = pop_addr;
                                sp_inc   = 1'b1;
                                hi_d     = dmem.rdata;
                                stall    = 1'b1;
                                state_d  = S_RTI2;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALL2: begin
                    mem_we    = 1'b1;
                    mem_addr  = push_addr;
                    mem_wdata = pc_q[31:16];
                    sp_dec    = 1'b1;
                    state_d   = S_IDLE;
                end
                S_RET2: begin
                    mem_re   = 1'b1;
                    mem_addr = pop_addr;
                    sp_inc   = 1'b1;
                    pc_load  = 1'b1;
                    pc_out   = {hi_q, dmem.rdata};
                    state_d  = S_IDLE;
                end
                S_INT2: begin
                    mem_we    = 1'b1;
                    mem_addr  = push_addr;
                    mem_wdata = pc_q[15:0];
                    sp_dec    = 1'b1;
                    stall     = 1'b1;
                    state_d   = S_INT3;
                end
                S_INT3: begin
                    mem_we    = 1'b1;
                    mem_addr  = push_addr;
                    mem_wdata = pc_q[31:16];
                    sp_dec    = 1'b1;
                    state_d   = S_IDLE;
                end
                S_RTI2: begin
                    mem_re   = 1'b1;
                    mem_addr = pop_addr;
                    sp_inc   = 1'b1;
                    lo_d     = dmem.rdata;
                    stall    = 1'b1;
                    state_d  = S_RTI3;
                end
                S_RTI3: begin
                    mem_re   = 1'b1;
                    mem_addr = pop_addr;
                    sp_inc   = 1'b1;
                    pc_load  = 1'b1;
                    pc_out   = {hi_q, lo_q};
                    ccr_load = 1'b1;
                    ccr_out  = dmem.rdata[3:0];
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
            pc_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pc_q    <= pc_d;
        end
    end

    assign dmem.addr  = mem_addr;
    assign dmem.re    = mem_re;
    assign dmem.we    = mem_we;
    assign dmem.wdata = mem_wdata;
    assign load_data  = dmem.rdata;

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the pipelined processor, directly downstream of execute. It takes each operation from the execute/memory buffer and drives the data-memory port. It owns the stack pointer and sequences the multi-cycle stack operations (CALL, RET, INT, RTI) with a small FSM. It returns load/pop data to write-back and restored PC/CCR to fetch and flags, and stalls upstream while a sequence is in progress.

## Interface
- SP_INIT, 32'h0000_07FF, stack pointer value after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation present from execute/memory buffer
- op_kind  in  4  NONE=0, LOAD=1, STORE=2, PUSH=3, POP=4, CALL=5, RET=6, INT=7, RTI=8
- alu_result  in  16  address for LOAD/STORE
- store_data  in  16  data for STORE/PUSH
- pc_in  in  32  return address for CALL/INT, already incremented upstream
- ccr_in  in  4  flags {NF,OF,CF,ZF} saved by INT
- mem_rdata  in  16  data-memory read data, combinational on mem_addr
- mem_addr  out  16  data-memory address
- mem_re, mem_we  out  1 each  read / write strobes; memory writes on clk edge
- mem_wdata  out  16  write data
- stall  out  1  freeze upstream pipeline this cycle
- load_valid  out  1  load_data valid for write-back (LOAD, POP)
- load_data  out  16  equals mem_rdata
- pc_load  out  1  fetch must load pc_out (RET/RTI final cycle)
- pc_out  out  32  restored PC
- ccr_load  out  1  flags must load ccr_out (RTI final cycle)
- ccr_out  out  4  restored flags
- sp  out  32  current stack pointer

## Operation
- Stack grows downward. A push writes at sp, then sp-1. A pop reads at sp+1, then sp+1. mem_addr = sp[15:0] or (sp+1)[15:0].
- LOAD: mem_re, addr=alu_result, load_valid. STORE: mem_we, addr=alu_result, wdata=store_data. PUSH: write store_data. POP: read with load_valid. All four take 1 cycle.
- CALL takes 2 cycles: push pc_in[15:0], then push pc_in[31:16].
- RET takes 2 cycles: pop high word into a latch, then pop low word. Final cycle: pc_load=1, pc_out={latched high, mem_rdata}.
- INT takes 3 cycles: push {12'b0, ccr_in}, push pc low, push pc high.
- RTI takes 3 cycles: pop high, pop low (both latched), pop ccr. Final cycle: pc_load=1 and ccr_load=1 together, ccr_out=mem_rdata[3:0].
- FSM states: IDLE, CALL2, RET2, INT2, INT3, RTI2, RTI3.
  - From IDLE, a valid CALL/RET/INT/RTI moves to its second state.
  - INT2 moves to INT3; RTI2 moves to RTI3.
  - The final state of every sequence returns to IDLE.
- pc_in and ccr_in are captured in the first cycle of a sequence. Inputs are ignored in non-IDLE states.
- stall = 1 in every cycle of a multi-cycle op except its last, including the first (IDLE) cycle. Otherwise stall = 0.
- op_valid=0 or op_kind=NONE/undefined: no strobes, sp unchanged.
- sp arithmetic wraps modulo 2^32 with no over/underflow detection. mem_addr uses low 16 bits.

## Timing
- Reset: state=IDLE, sp=SP_INIT, latches cleared. While reset is high, all strobes, stall, pc_load, ccr_load and load_valid are 0.
- Reset mid-sequence aborts it: no further writes, no pc_load/ccr_load, sp=SP_INIT next cycle. Words already written stay in memory.
- Strobes and addresses are combinational from state and inputs; sp updates at the end of each access cycle.
- Latency: the result of every access is available in the same cycle.
- Back-to-back ops: a new op may be accepted in the cycle after the final cycle of a sequence.

## Structure
- Shared package holds the op_kind codes, FSM state encoding, and the SP_INIT default. Execute and write-back stages import the same codes.
- One sub-module, sp_counter: 32-bit register with reset-to-SP_INIT and dec/inc enables. The previous stack-pointer module is retired.

## Test plan
- PUSH store_data=0xBEEF: we, addr 0x07FF, wdata 0xBEEF, sp→0x7FE. Next POP: re, addr 0x07FF, load_data=0xBEEF, load_valid=1, sp→0x7FF.
- CALL pc_in=0x0001_0024:
  - Cycle 0: addr 0x7FF, wdata 0x0024, stall=1.
  - Cycle 1: addr 0x7FE, wdata 0x0001, stall=0; sp→0x7FD.
  - RET reads 0x7FE then 0x7FF. Cycle 1: pc_load=1, pc_out=0x0001_0024, sp→0x7FF.
- INT ccr_in=4'b1010, pc_in=0x0000_0100:
  - Writes 0x000A@7FF, 0x0100@7FE, 0x0000@7FD; stall=1,1,0; sp→0x7FC.
  - RTI third cycle: pc_load=ccr_load=1, pc_out=0x100, ccr_out=1010.
- Reset asserted after CALL cycle 0: no write in the following cycle, sp=0x7FF, stall=0, state IDLE.
- SP_INIT=0: PUSH writes addr 0x0000, sp→0xFFFF_FFFF. Second PUSH writes addr 0xFFFF.
- STORE alu_result=0x0010 data 0x1234, then LOAD 0x0010 returns 0x1234. op_valid=0 with op_kind=PUSH produces no strobe and sp is unchanged.
